sd_block_rx: RTL



---
 rtl/sd_block_rx.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/sd_block_rx.sv
// SPI-mode SD single-block data receiver: hunts the start token, streams the
// data bytes out and checks the trailing CRC16-CCITT.
module sd_block_rx #(
  parameter int BLOCK_BYTES   = 4,
  parameter int IDX_W         = 2,
  parameter int TOKEN_TIMEOUT = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             D0,
  output logic             busy,
  output logic [7:0]       byte_data,
  output logic             byte_valid,
  output logic [IDX_W-1:0] byte_index,
  output logic             done,
  output logic             crc_ok,
  output logic             error,
  output logic             timeout,
  output logic [7:0]       err_token
);

  localparam int HUNT_W = $clog2(TOKEN_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, TOKEN, DATA, CRC, FINISH} state_t;

  state_t           state, state_next;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt;
  logic [IDX_W-1:0] byte_cnt;
  logic [HUNT_W-1:0] hunt_cnt;
  logic [15:0]      crc_calc;
  logic [7:0]       crc_hi;
  logic             crc_half;
  logic             in_frame;
  logic             byte_done;
  logic [7:0]       rx_byte;
  logic             hunt_last;
  logic             data_last;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[15] ^ d[7-i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else                r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // The byte being completed includes the bit sampled on this very edge.
  always_comb begin
    in_frame  = (state == TOKEN) || (state == DATA) || (state == CRC);
    rx_byte   = {shift_q[6:0], D0};
    byte_done = in_frame && (bit_cnt == 3'd7);
    hunt_last = (hunt_cnt == HUNT_W'(TOKEN_TIMEOUT - 1));
    data_last = (byte_cnt == IDX_W'(BLOCK_BYTES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (start) state_next = TOKEN;
      TOKEN:  if (byte_done) begin
                if (rx_byte == 8'hFF) begin
                  if (hunt_last) state_next = FINISH;
                end else if (rx_byte == 8'hFE) begin
                  state_next = DATA;
                end else begin
                  state_next = FINISH;
                end
              end
      DATA:   if (byte_done && data_last) state_next = CRC;
      CRC:    if (byte_done && crc_half) state_next = FINISH;
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = in_frame;
  assign done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      hunt_cnt   <= '0;
      crc_calc   <= '0;
      crc_hi     <= '0;
      crc_half   <= 1'b0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_index <= '0;
      crc_ok     <= 1'b0;
      error      <= 1'b0;
      timeout    <= 1'b0;
      err_token  <= '0;
    end else begin
      byte_valid <= 1'b0;
      if (state == IDLE) begin
        bit_cnt <= '0;
        if (start) begin
          crc_ok    <= 1'b0;
          error     <= 1'b0;
          timeout   <= 1'b0;
          err_token <= '0;
          hunt_cnt  <= '0;
        end
      end
      if (in_frame) begin
        shift_q <= rx_byte;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (byte_done) begin
        unique case (state)
          TOKEN: begin
            if (rx_byte == 8'hFF) begin
              hunt_cnt <= hunt_cnt + HUNT_W'(1);
              if (hunt_last) begin
                error   <= 1'b1;
                timeout <= 1'b1;
              end
            end else if (rx_byte == 8'hFE) begin
              byte_cnt <= '0;
              crc_calc <= '0;
              crc_half <= 1'b0;
            end else begin
              err_token <= rx_byte;
              error     <= 1'b1;
            end
          end
          DATA: begin
            byte_data  <= rx_byte;
            byte_index <= byte_cnt;
            byte_valid <= 1'b1;
            crc_calc   <= crc16_byte(crc_calc, rx_byte);
            byte_cnt   <= byte_cnt + IDX_W'(1);
          end
          CRC: begin
            crc_hi   <= rx_byte;
            crc_half <= ~crc_half;
            if (crc_half) crc_ok <= ({crc_hi, rx_byte} == crc_calc);
          end
          default: ;
        endcase
      end
    end
  end

endmodule
